// File: rtl/spram_sleep_ctrl.sv
// spram_sleep_ctrl: single-port huge-RAM wrapper with a valid/ready port, nibble write mask,
// optional output register and sleep/wake sequencing. Optional parity: SPRAM_SLEEP_CTRL_PARITY_EN.
module spram_sleep_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 14,
  parameter int OUT_REG     = 0,
  parameter int WAKE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [DATA_WIDTH/4-1:0] req_mask,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_perr,
  input  logic                    sleep_req,
  output logic                    sleep_ack
);
  // state  | meaning
  // ACTIVE | requests accepted while sleep_req is low
  // DRAIN  | no new requests; waiting for in-flight reads to respond
  // SLEEP  | memory retained and idle; sleep_ack high
  // WAKE   | counting WAKE_CYCLES down before returning to ACTIVE
  localparam logic [1:0] S_ACTIVE = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_SLEEP  = 2'd2;
  localparam logic [1:0] S_WAKE   = 2'd3;

  localparam int NIB   = DATA_WIDTH / 4;
  localparam int CNT_W = $clog2(WAKE_CYCLES + 1);
`ifdef SPRAM_SLEEP_CTRL_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + NIB;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif

  (* ram_style = "huge" *) logic [MEM_W-1:0] r_mem [0:2**ADDR_WIDTH-1];

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_wake_cnt;
  logic                  r_pipe_v1;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_perr;
  logic                  w_accept;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_inflight;
  logic                  w_rsp_valid;
  logic                  w_rd_perr;
  logic [MEM_W-1:0]      w_rd_word;

  assign req_ready = (r_state == S_ACTIVE) && !sleep_req;
  assign w_accept  = req_valid && req_ready;
  assign w_rd      = w_accept && !req_we;
  assign w_wr      = w_accept && req_we;
  assign w_rd_word = r_mem[req_addr];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < NIB; i++) begin
        if (req_mask[i]) begin
          r_mem[req_addr][4*i +: 4] <= req_wdata[4*i +: 4];
`ifdef SPRAM_SLEEP_CTRL_PARITY_EN
          r_mem[req_addr][DATA_WIDTH+i] <= ^req_wdata[4*i +: 4];
`endif
        end
      end
    end
  end

`ifdef SPRAM_SLEEP_CTRL_PARITY_EN
  // Each stored nibble plus its parity bit must hold an even number of ones.
  always_comb begin
    w_rd_perr = 1'b0;
    for (int i = 0; i < NIB; i++) begin
      w_rd_perr = w_rd_perr | (^{w_rd_word[4*i +: 4], w_rd_word[DATA_WIDTH+i]});
    end
  end
`else
  assign w_rd_perr = 1'b0;
`endif

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] r_rd_q;
      logic                  r_perr_q;
      logic                  r_pipe_v2;

      always_ff @(posedge clk) begin
        if (w_rd) begin
          r_rd_q   <= w_rd_word[DATA_WIDTH-1:0];
          r_perr_q <= w_rd_perr;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pipe_v2  <= 1'b0;
          r_rsp_data <= '0;
          r_rsp_perr <= 1'b0;
        end else begin
          r_pipe_v2 <= r_pipe_v1;
          if (r_pipe_v1) begin
            r_rsp_data <= r_rd_q;
            r_rsp_perr <= r_perr_q;
          end
        end
      end

      // A read in the first stage still owes a response next cycle.
      assign w_inflight  = r_pipe_v1;
      assign w_rsp_valid = r_pipe_v2;
    end else begin : g_noreg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rsp_data <= '0;
          r_rsp_perr <= 1'b0;
        end else if (w_rd) begin
          r_rsp_data <= w_rd_word[DATA_WIDTH-1:0];
          r_rsp_perr <= w_rd_perr;
        end
      end

      assign w_inflight  = 1'b0;
      assign w_rsp_valid = r_pipe_v1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_ACTIVE;
      r_wake_cnt <= '0;
      r_pipe_v1  <= 1'b0;
    end else begin
      r_pipe_v1 <= w_rd;
      case (r_state)
        S_ACTIVE: if (sleep_req) r_state <= S_DRAIN;
        S_DRAIN:  if (!w_inflight) r_state <= S_SLEEP;
        S_SLEEP: begin
          if (!sleep_req) begin
            r_state    <= S_WAKE;
            r_wake_cnt <= CNT_W'(WAKE_CYCLES);
          end
        end
        S_WAKE: begin
          r_wake_cnt <= r_wake_cnt - CNT_W'(1);
          if (r_wake_cnt == CNT_W'(1)) r_state <= S_ACTIVE;
        end
        default: r_state <= S_ACTIVE;
      endcase
    end
  end

  assign rsp_valid = w_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_perr  = r_rsp_perr;
  assign sleep_ack = (r_state == S_SLEEP);

endmodule

// File: doc/spram_sleep_ctrl.md
Name: spram_sleep_ctrl

Overview:
- Parametrised single-port RAM for ice40 SPRAM-class inference (ram_style "huge").
- Adds a valid/ready request port, nibble write mask, an optional output register and a sleep/wake power state machine with data retention.
- Sits between a bus master and the on-chip huge RAM.
- Replaces the fixed 8x8, write-priority test RAM.

Parameters:
- DATA_WIDTH, 16, word width; must be a multiple of 4.
- ADDR_WIDTH, 14, word address width; depth = 2**ADDR_WIDTH.
- OUT_REG, 0, 1 adds an output pipeline register (read latency 2 instead of 1).
- WAKE_CYCLES, 3, cycles spent in WAKE before accepting requests; must be >= 1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_mask  in  DATA_WIDTH/4  per-nibble write enable; ignored on reads.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle pulse, read data valid.
- rsp_data  out  DATA_WIDTH  read data; holds its last value between pulses.
- rsp_perr  out  1  parity error flag, qualified by rsp_valid.
- sleep_req  in  1  level request to enter sleep.
- sleep_ack  out  1  high while in SLEEP.

Behaviour:
- Reset (rst_n low, async):
  - state=ACTIVE; rsp_valid=0, rsp_data=0, rsp_perr=0, sleep_ack=0.
  - Wake counter=0; pipeline valid bits cleared.
  - Memory contents are not reset.
- req_ready = (state==ACTIVE) && !sleep_req, combinational.
- Accepted write: on that edge, nibble i of mem[req_addr] <= req_wdata nibble i for each req_mask[i]=1. Unmasked nibbles are retained. No response.
- Accepted write with req_mask=0: no state change.
- Accepted read:
  - OUT_REG=0: rsp_valid=1 and rsp_data=mem[addr] on the next cycle.
  - OUT_REG=1: one cycle later.
- Back-to-back reads give one response per cycle, in order.
- Write followed by read of the same address on the next cycle returns the new data.
- No read-during-write: a write cycle never updates rsp_data.
- FSM:
  - ACTIVE: sleep_req=1 -> DRAIN.
  - DRAIN: no new requests. -> SLEEP once no read is in flight (0 cycles in-flight possible; DRAIN always lasts at least 1 cycle). Completes even if sleep_req drops.
  - SLEEP: sleep_ack=1. Memory is retained and not accessed. sleep_req=0 -> WAKE; the counter loads WAKE_CYCLES.
  - WAKE: the counter decrements each cycle; at 1 -> ACTIVE. sleep_req is ignored until ACTIVE is reached.
- sleep_ack falls on the cycle leaving SLEEP.
- Reads accepted before sleep_req rises always complete with rsp_valid before sleep_ack rises.
- Reset mid-DRAIN or mid-WAKE: immediate ACTIVE; in-flight responses are discarded (no rsp_valid).
- Address is full range, with no wrap logic needed. Out-of-range cannot occur.

Optional Feature:
- Macro SPRAM_SLEEP_CTRL_PARITY_EN.
- Defined:
  - Memory stores one even-parity bit per nibble, written with the masked nibble.
  - On a read, rsp_perr=1 if any nibble parity mismatches. It is registered alongside rsp_data with the same latency.
  - Memory width becomes DATA_WIDTH + DATA_WIDTH/4.
- Undefined: no parity storage; rsp_perr is tied to 0.

Test Plan:
- Write/readback, OUT_REG=0:
  - Stimulus: write addr 0x0005 data 0xBEEF mask 0xF, then read 0x0005.
  - Response: rsp_valid exactly 1 cycle after read acceptance; rsp_data=0xBEEF; rsp_perr=0.
- Nibble mask:
  - Stimulus: write 0x0010 data 0x1234 mask 0xF; write 0x0010 data 0xABCD mask 0x5; read 0x0010.
  - Response: rsp_data=0x1B3D.
- Streaming, OUT_REG=1:
  - Stimulus: reads of 0x0001, 0x0002, 0x0003 on consecutive cycles (preloaded 0x1111/0x2222/0x3333).
  - Response: three consecutive rsp_valid pulses starting 2 cycles after the first accept, in order. rsp_data holds 0x3333 afterwards.
- Sleep/wake:
  - Stimulus: read accepted, sleep_req raised the next cycle, held 10 cycles, then dropped.
  - Response: the read response arrives before sleep_ack=1. req_ready stays 0 through SLEEP and for WAKE_CYCLES=3 cycles after sleep_ack falls. Data at 0x0005 still reads 0xBEEF.
- Contention:
  - Stimulus: req_valid and sleep_req both rise on the same cycle while in ACTIVE.
  - Response: req_ready=0 and the request is not accepted. The request is accepted on the first ACTIVE cycle after wake, once sleep_req=0.
- Async reset mid-WAKE:
  - Stimulus: assert rst_n=0 for 1 cycle in WAKE.
  - Response: immediate state ACTIVE; outputs zero; req_ready=1 after release; memory contents unchanged.
